// File: rtl/regfile_writeback_pkg.sv
// Shared constants and payload types for the register-file write side.
package regfile_writeback_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    // Architectural x0: hardwired zero, never written and never tracked.
    localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

    // Winner of the write-port arbitration in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } wb_src_e;

    // One result headed for the register file.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_payload_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Issue, result, operand-lookup and write-port signals of the writeback block.
interface regfile_writeback_if;
    import regfile_writeback_pkg::*;

    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_ready;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              mem_ready;

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rs1_fwd;
    logic              rs2_fwd;

    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    // Writeback block side.
    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  rs1, rs2,
        output issue_ready, alu_ready, mem_ready,
        output rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
        output wb_we, wb_rd, wb_data
    );

    // Pipeline / register-file side.
    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output rs1, rs2,
        input  issue_ready, alu_ready, mem_ready,
        input  rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
        input  wb_we, wb_rd, wb_data
    );

endinterface

// File: rtl/regfile_writeback_scoreboard.sv
// Per-register pending bits: set at issue, cleared at retire, set wins on collision.
module regfile_writeback_scoreboard
    import regfile_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_idx,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_idx,
    input  logic [REG_AW-1:0] i_issue_idx,
    input  logic [REG_AW-1:0] i_rs1_idx,
    input  logic [REG_AW-1:0] i_rs2_idx,
    output logic              o_issue_busy_c,
    output logic              o_rs1_busy_c,
    output logic              o_rs2_busy_c
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Next busy vector: clear first so a same-index set overrides it; x0 stays clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en && (i_set_idx != REG_ZERO)) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Raw lookups; x0 and forwarding qualification happen in the parent.
    always_comb begin
        o_issue_busy_c = r_busy[i_issue_idx];
        o_rs1_busy_c   = r_busy[i_rs1_idx];
        o_rs2_busy_c   = r_busy[i_rs2_idx];
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-side controller: ALU/load arbitration, one-cycle write
// register, pending scoreboard and writeback-stage forwarding hints.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter bit MEM_PRIORITY = 1'b1
)
(
    input  logic                 clk,
    input  logic                 resetn,
    regfile_writeback_if.slave   io_bus
);

    logic        w_alu_ready;
    logic        w_mem_ready;
    wb_src_e     w_src;
    wb_payload_t w_sel;

    logic        r_wb_we;
    wb_payload_t r_wb;

    logic        w_issue_busy;
    logic        w_rs1_busy_raw;
    logic        w_rs2_busy_raw;
    logic        w_issue_ready;
    logic        w_issue_set;
    logic        w_rs1_fwd;
    logic        w_rs2_fwd;

    // Fixed-priority arbitration; the loser sees ready low and holds its result.
    always_comb begin
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (MEM_PRIORITY) begin
            w_mem_ready = io_bus.mem_valid;
            w_alu_ready = io_bus.alu_valid & ~io_bus.mem_valid;
        end else begin
            w_alu_ready = io_bus.alu_valid;
            w_mem_ready = io_bus.mem_valid & ~io_bus.alu_valid;
        end
    end

    // Select the accepted payload for the write register.
    always_comb begin
        w_src = SRC_NONE;
        w_sel = '0;
        if (w_mem_ready) begin
            w_src      = SRC_MEM;
            w_sel.rd   = io_bus.mem_rd;
            w_sel.data = io_bus.mem_data;
        end else if (w_alu_ready) begin
            w_src      = SRC_ALU;
            w_sel.rd   = io_bus.alu_rd;
            w_sel.data = io_bus.alu_data;
        end
    end

    // Write-port register: x0 results are consumed but never raise the write enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wb_we <= 1'b0;
            r_wb    <= '0;
        end else if (w_src != SRC_NONE) begin
            r_wb_we <= (w_sel.rd != REG_ZERO);
            r_wb    <= w_sel;
        end else begin
            r_wb_we <= 1'b0;
        end
    end

    // WAW check: a register retiring this cycle may be re-issued immediately.
    always_comb begin
        w_issue_ready = (io_bus.issue_rd == REG_ZERO) | ~w_issue_busy
                      | (r_wb_we & (r_wb.rd == io_bus.issue_rd));
        w_issue_set   = io_bus.issue_valid & w_issue_ready;
    end

    regfile_writeback_scoreboard u_scoreboard (
        .clk            (clk),
        .resetn         (resetn),
        .i_set_en       (w_issue_set),
        .i_set_idx      (io_bus.issue_rd),
        .i_clr_en       (r_wb_we),
        .i_clr_idx      (r_wb.rd),
        .i_issue_idx    (io_bus.issue_rd),
        .i_rs1_idx      (io_bus.rs1),
        .i_rs2_idx      (io_bus.rs2),
        .o_issue_busy_c (w_issue_busy),
        .o_rs1_busy_c   (w_rs1_busy_raw),
        .o_rs2_busy_c   (w_rs2_busy_raw)
    );

    // Operand hints: a pending register being written right now is forwardable.
    always_comb begin
        w_rs1_fwd = r_wb_we & (r_wb.rd == io_bus.rs1) & (io_bus.rs1 != REG_ZERO);
        w_rs2_fwd = r_wb_we & (r_wb.rd == io_bus.rs2) & (io_bus.rs2 != REG_ZERO);
    end

    // Drive the interface.
    always_comb begin
        io_bus.issue_ready = w_issue_ready;
        io_bus.alu_ready   = w_alu_ready;
        io_bus.mem_ready   = w_mem_ready;
        io_bus.rs1_fwd     = w_rs1_fwd;
        io_bus.rs2_fwd     = w_rs2_fwd;
        io_bus.rs1_busy    = w_rs1_busy_raw & ~w_rs1_fwd & (io_bus.rs1 != REG_ZERO);
        io_bus.rs2_busy    = w_rs2_busy_raw & ~w_rs2_fwd & (io_bus.rs2 != REG_ZERO);
        io_bus.wb_we       = r_wb_we;
        io_bus.wb_rd       = r_wb.rd;
        io_bus.wb_data     = r_wb.data;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: per-cycle vector table plus reset and
// ALU-priority sequences.
module tb_regfile_writeback;

    logic clk;
    logic resetn;

    int checks;
    int errors;

    regfile_writeback_if bus ();
    regfile_writeback_if bus0 ();

    regfile_writeback #(.MEM_PRIORITY(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus)
    );

    regfile_writeback #(.MEM_PRIORITY(1'b0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ir;
        logic        ar;
        logic        mr;
        logic        r1b;
        logic        r1f;
        logic        r2b;
        logic        r2f;
        logic        we;
        logic        wchk;
        logic [4:0]  wrd;
        logic [31:0] wdat;
    } vec_t;

    localparam int unsigned NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] ird,
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic ir, input logic ar, input logic mr,
        input logic r1b, input logic r1f, input logic r2b, input logic r2f,
        input logic we, input logic wchk, input logic [4:0] wrd, input logic [31:0] wdat);
        vec_t v;
        v.iv = iv;   v.ird = ird;
        v.av = av;   v.ard = ard;   v.adat = adat;
        v.mv = mv;   v.mrd = mrd;   v.mdat = mdat;
        v.rs1 = rs1; v.rs2 = rs2;
        v.ir = ir;   v.ar = ar;     v.mr = mr;
        v.r1b = r1b; v.r1f = r1f;   v.r2b = r2b; v.r2f = r2f;
        v.we = we;   v.wchk = wchk; v.wrd = wrd; v.wdat = wdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        bus.alu_valid   = v.av;
        bus.alu_rd      = v.ard;
        bus.alu_data    = v.adat;
        bus.mem_valid   = v.mv;
        bus.mem_rd      = v.mrd;
        bus.mem_data    = v.mdat;
        bus.rs1         = v.rs1;
        bus.rs2         = v.rs2;
    endtask

    task automatic idle_bus0();
        bus0.issue_valid = 1'b0;
        bus0.issue_rd    = 5'd0;
        bus0.alu_valid   = 1'b0;
        bus0.alu_rd      = 5'd0;
        bus0.alu_data    = 32'h0;
        bus0.mem_valid   = 1'b0;
        bus0.mem_rd      = 5'd0;
        bus0.mem_data    = 32'h0;
        bus0.rs1         = 5'd0;
        bus0.rs2         = 5'd0;
    endtask

    initial begin
        vec_t z;
        checks = 0;
        errors = 0;

        //          iv ird  av ard adat          mv mrd mdat         rs1 rs2  ir ar mr r1b r1f r2b r2f we chk wrd wdat
        vecs[0]  = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h0);
        // single ALU result to x3
        vecs[1]  = mk(1, 3,  0, 0, 32'h0,        0, 0, 32'h0,        3, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h0);
        vecs[2]  = mk(0, 3,  1, 3, 32'hDEADBEEF, 0, 0, 32'h0,        3, 0,   0, 1, 0, 1, 0, 0, 0,  0, 1, 0, 32'h0);
        vecs[3]  = mk(0, 3,  0, 0, 32'h0,        0, 0, 32'h0,        3, 3,   1, 0, 0, 0, 1, 0, 1,  1, 1, 3, 32'hDEADBEEF);
        vecs[4]  = mk(0, 3,  0, 0, 32'h0,        0, 0, 32'h0,        3, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 3, 32'hDEADBEEF);
        // contention, load wins
        vecs[5]  = mk(0, 0,  1, 4, 32'h11,       1, 5, 32'h22,       0, 0,   1, 0, 1, 0, 0, 0, 0,  0, 1, 3, 32'hDEADBEEF);
        vecs[6]  = mk(0, 0,  1, 4, 32'h11,       0, 0, 32'h0,        5, 0,   1, 1, 0, 0, 1, 0, 0,  1, 1, 5, 32'h22);
        vecs[7]  = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        5, 4,   1, 0, 0, 0, 0, 0, 1,  1, 1, 4, 32'h11);
        // WAW on x7, same-edge set/clear keeps busy
        vecs[8]  = mk(1, 7,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 4, 32'h11);
        vecs[9]  = mk(1, 7,  1, 7, 32'h77,       0, 0, 32'h0,        7, 0,   0, 1, 0, 1, 0, 0, 0,  0, 1, 4, 32'h11);
        vecs[10] = mk(1, 7,  0, 0, 32'h0,        0, 0, 32'h0,        7, 0,   1, 0, 0, 0, 1, 0, 0,  1, 1, 7, 32'h77);
        vecs[11] = mk(0, 7,  0, 0, 32'h0,        0, 0, 32'h0,        7, 0,   0, 0, 0, 1, 0, 0, 0,  0, 1, 7, 32'h77);
        vecs[12] = mk(0, 7,  1, 7, 32'h78,       0, 0, 32'h0,        7, 0,   0, 1, 0, 1, 0, 0, 0,  0, 1, 7, 32'h77);
        vecs[13] = mk(0, 7,  0, 0, 32'h0,        0, 0, 32'h0,        7, 0,   1, 0, 0, 0, 1, 0, 0,  1, 1, 7, 32'h78);
        // x0 result and x0 issue
        vecs[14] = mk(1, 0,  1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 7,   1, 1, 0, 0, 0, 0, 0,  0, 1, 7, 32'h78);
        vecs[15] = mk(1, 0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0);
        // back-to-back loads to x1..x3
        vecs[16] = mk(1, 1,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0);
        vecs[17] = mk(1, 2,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0);
        vecs[18] = mk(1, 3,  0, 0, 32'h0,        0, 0, 32'h0,        1, 2,   1, 0, 0, 1, 0, 1, 0,  0, 0, 0, 32'h0);
        vecs[19] = mk(0, 0,  0, 0, 32'h0,        1, 1, 32'hA1,       1, 3,   1, 0, 1, 1, 0, 1, 0,  0, 0, 0, 32'h0);
        vecs[20] = mk(0, 0,  0, 0, 32'h0,        1, 2, 32'hA2,       1, 2,   1, 0, 1, 0, 1, 1, 0,  1, 1, 1, 32'hA1);
        vecs[21] = mk(0, 0,  0, 0, 32'h0,        1, 3, 32'hA3,       1, 2,   1, 0, 1, 0, 0, 0, 1,  1, 1, 2, 32'hA2);
        vecs[22] = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        2, 3,   1, 0, 0, 0, 0, 0, 1,  1, 1, 3, 32'hA3);
        vecs[23] = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        3, 3,   1, 0, 0, 0, 0, 0, 0,  0, 1, 3, 32'hA3);

        // Reset state
        z = mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drive(z);
        idle_bus0();
        resetn = 1'b0;
        #1;
        chk("rst_wb_we",   32'(bus.wb_we),   32'h0);
        chk("rst_wb_rd",   32'(bus.wb_rd),   32'h0);
        chk("rst_wb_data", bus.wb_data,      32'h0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'h1);
        #11;
        resetn = 1'b1;

        // Vector table: drive at negedge, sample 1 ns later (before next posedge)
        for (int i = 0; i < int'(NV); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_issue_ready", i), 32'(bus.issue_ready), 32'(vecs[i].ir));
            chk($sformatf("v%0d_alu_ready", i),   32'(bus.alu_ready),   32'(vecs[i].ar));
            chk($sformatf("v%0d_mem_ready", i),   32'(bus.mem_ready),   32'(vecs[i].mr));
            chk($sformatf("v%0d_rs1_busy", i),    32'(bus.rs1_busy),    32'(vecs[i].r1b));
            chk($sformatf("v%0d_rs1_fwd", i),     32'(bus.rs1_fwd),     32'(vecs[i].r1f));
            chk($sformatf("v%0d_rs2_busy", i),    32'(bus.rs2_busy),    32'(vecs[i].r2b));
            chk($sformatf("v%0d_rs2_fwd", i),     32'(bus.rs2_fwd),     32'(vecs[i].r2f));
            chk($sformatf("v%0d_wb_we", i),       32'(bus.wb_we),       32'(vecs[i].we));
            if (vecs[i].wchk) begin
                chk($sformatf("v%0d_wb_rd", i),   32'(bus.wb_rd),       32'(vecs[i].wrd));
                chk($sformatf("v%0d_wb_data", i), bus.wb_data,          vecs[i].wdat);
            end
        end

        // Mid-run async reset with x5 pending and a write in flight
        @(negedge clk);
        drive(mk(1, 5, 1, 6, 32'h66, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        @(negedge clk);
        drive(mk(0, 5, 0, 0, 32'h0, 0, 0, 32'h0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        #1;
        chk("pre_rst_issue_ready", 32'(bus.issue_ready), 32'h0);
        chk("pre_rst_wb_we",       32'(bus.wb_we),       32'h1);
        chk("pre_rst_rs1_busy",    32'(bus.rs1_busy),    32'h1);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_wb_we",       32'(bus.wb_we),       32'h0);
        chk("mid_rst_wb_rd",       32'(bus.wb_rd),       32'h0);
        chk("mid_rst_wb_data",     bus.wb_data,          32'h0);
        chk("mid_rst_issue_ready", 32'(bus.issue_ready), 32'h1);
        chk("mid_rst_rs1_busy",    32'(bus.rs1_busy),    32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_issue_ready", 32'(bus.issue_ready), 32'h1);
        chk("post_rst_wb_we",       32'(bus.wb_we),       32'h0);

        // ALU-priority instance: ALU wins, load held one cycle
        @(negedge clk);
        bus0.alu_valid = 1'b1; bus0.alu_rd = 5'd4; bus0.alu_data = 32'h11;
        bus0.mem_valid = 1'b1; bus0.mem_rd = 5'd5; bus0.mem_data = 32'h22;
        #1;
        chk("p0_alu_ready", 32'(bus0.alu_ready), 32'h1);
        chk("p0_mem_ready", 32'(bus0.mem_ready), 32'h0);
        @(negedge clk);
        bus0.alu_valid = 1'b0;
        #1;
        chk("p0_mem_ready_2", 32'(bus0.mem_ready), 32'h1);
        chk("p0_wb_we_1",     32'(bus0.wb_we),     32'h1);
        chk("p0_wb_rd_1",     32'(bus0.wb_rd),     32'h4);
        chk("p0_wb_data_1",   bus0.wb_data,        32'h11);
        @(negedge clk);
        bus0.mem_valid = 1'b0;
        #1;
        chk("p0_wb_we_2",     32'(bus0.wb_we),     32'h1);
        chk("p0_wb_rd_2",     32'(bus0.wb_rd),     32'h5);
        chk("p0_wb_data_2",   bus0.wb_data,        32'h22);
        @(negedge clk);
        #1;
        chk("p0_wb_we_3",     32'(bus0.wb_we),     32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
